nec_prefetch: RTL
=================

NEC_PREFETCH -- requirements
Module: nec_prefetch

Interface
REQ-001 SHALL have ports: clk  in  1  core clock; reset  in  1  synchronous, active-high.
REQ-002 SHALL have ports: ce_1 / ce_2  in  1 each  phase clock enables; all state advances only on ce_1.
REQ-003 SHALL have decoder-side ports: decode_pc  in  16  decoder's current PC; set_pc  in  1  flush request; new_pc  in  16  flush target; block_prefetch  in  1  inhibit new prefetches.
REQ-004 SHALL have queue outputs: ipq  out  8x8  byte ring indexed by address[2:0]; ipq_len  out  4  valid bytes from decode_pc, 0..8.
REQ-005 SHALL have execution-unit ports: exec_req  in  1  EU wants the bus; exec_grant  out  1  EU owns the bus; exec_done  in  1  EU releases the bus.
REQ-006 SHALL have bus ports: bus_req  out  1; bus_addr  out  16; bus_fetch  out  1 (1 = prefetch cycle); bus_ready  in  1  1-cycle completion strobe; bus_din  in  16  read data, sampled with bus_ready.
REQ-007 SHALL take no parameters; queue depth is fixed at 8 bytes, bus width at 16 bits.

Function
REQ-008 SHALL keep fetch_addr (16 bits); ipq_len = fetch_addr - decode_pc (16-bit wrap-around subtraction), saturated to 8.
REQ-009 SHALL implement states IDLE, PF_BUSY, EX_BUSY.
REQ-010 IDLE -> EX_BUSY when exec_req=1; exec_grant asserts on that same ce_1 edge. exec_req has priority over prefetch.
REQ-011 IDLE -> PF_BUSY when exec_req=0, block_prefetch=0, set_pc=0, and free bytes (8 - ipq_len) >= 2 (fetch_addr even) or >= 1 (fetch_addr odd).
REQ-012 On entry to PF_BUSY: bus_req=1, bus_fetch=1, bus_addr={fetch_addr[15:1],1'b0}; all three held until bus_ready.
REQ-013 PF_BUSY with bus_ready on ce_1, even fetch_addr: write bus_din[7:0] to ipq[a], bus_din[15:8] to ipq[a+1] (a = fetch_addr[2:0], index modulo 8); fetch_addr += 2.
REQ-014 PF_BUSY with bus_ready on ce_1, odd fetch_addr: write only bus_din[15:8] to ipq[a]; fetch_addr += 1.
REQ-015 PF_BUSY -> IDLE on bus_ready; bus_req drops the same edge. An in-flight prefetch is never aborted; exec_req waits for it to complete.
REQ-016 EX_BUSY: exec_grant=1, bus_req=0 from this block; -> IDLE on exec_done, with exec_grant cleared the same edge.
REQ-017 set_pc (ce_1 or ce_2) SHALL set fetch_addr=new_pc; ipq_len reads 0 on the next cycle.
REQ-018 set_pc during PF_BUSY SHALL set a discard flag. The completing bus_ready SHALL write no bytes and SHALL not advance fetch_addr. The discard flag clears on that completion.
REQ-019 set_pc and bus_ready on the same edge SHALL be treated as REQ-018 (data discarded, fetch_addr=new_pc).
REQ-020 Queue full (ipq_len=8) or block_prefetch=1 SHALL prevent leaving IDLE for PF_BUSY. Neither affects a cycle already in flight.
REQ-021 fetch_addr SHALL wrap 0xFFFF -> 0x0000 with no special handling.
REQ-022 ipq bytes not yet written hold stale data; the decoder consumes only within ipq_len.

Reset
REQ-023 On reset (sync, any ce): state=IDLE, fetch_addr=0x0000, discard=0, bus_req=0, bus_fetch=0, bus_addr=0, exec_grant=0, ipq contents=0x00.
REQ-024 Reset SHALL override set_pc, exec_req and bus_ready on the same edge. A bus cycle in flight is abandoned.

Verification
REQ-025 Reset, then set_pc new_pc=0x0100, decode_pc=0x0100, bus returns 0x2211,0x4433,... -> four word fetches at 0x0100/02/04/06, ipq_len=8, ipq[0..3]=11,22,33,44, then bus_req stays 0.
REQ-026 set_pc new_pc=0x0103 -> first bus_addr=0x0102, only ipq[3]=din[15:8], fetch_addr=0x0104, next fetch even.
REQ-027 exec_req during PF_BUSY -> prefetch completes, IDLE, exec_grant=1 on next ce_1, no bus_req until exec_done.
REQ-028 set_pc to 0x0200 while PF_BUSY at 0x0110 -> returned data not written, next bus_addr=0x0200, ipq_len=0 then 2.
REQ-029 Queue with ipq_len=7 and fetch_addr even -> no fetch; decode_pc+1 -> fetch issued. block_prefetch=1 with ipq_len=0 -> no bus_req.
REQ-030 fetch_addr=0xFFFE, decode_pc=0xFFFC -> fetch at 0xFFFE, fetch_addr=0x0000, ipq_len=4.

Source files
------------

// File: rtl/nec_prefetch.sv
// Instruction prefetch queue: an 8-byte ring filled over a 16-bit bus while idle,
// sharing the bus with the execution unit and flushed on decoder PC changes.
module nec_prefetch (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce_1,
    input  logic            ce_2,
    input  logic [15:0]     decode_pc,
    input  logic            set_pc,
    input  logic [15:0]     new_pc,
    input  logic            block_prefetch,
    output logic [7:0][7:0] ipq,
    output logic [3:0]      ipq_len,
    input  logic            exec_req,
    output logic            exec_grant,
    input  logic            exec_done,
    output logic            bus_req,
    output logic [15:0]     bus_addr,
    output logic            bus_fetch,
    input  logic            bus_ready,
    input  logic [15:0]     bus_din,
    output logic [1:0]      dbg_state     // 0 = IDLE, 1 = PF_BUSY, 2 = EX_BUSY
);

    // Bus handshake: bus_req/bus_addr/bus_fetch are held stable from the ce_1 edge
    // that starts a cycle until a ce_1 edge that samples bus_ready=1; bus_din is
    // valid only alongside bus_ready. exec_req is a level held until exec_grant.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PF_BUSY = 2'd1,
        EX_BUSY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     fetch_addr_q, fetch_addr_d;
    logic            discard_q, discard_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_fetch_q, bus_fetch_d;
    logic [15:0]     bus_addr_q, bus_addr_d;
    logic            exec_grant_q, exec_grant_d;
    logic [7:0][7:0] ipq_q, ipq_d;

    logic [15:0]     fetch_dist;
    logic            room;
    logic            set_pc_ev;
    logic [2:0]      idx, idx_n;

    assign fetch_dist = fetch_addr_q - decode_pc;
    assign ipq_len    = (fetch_dist > 16'd8) ? 4'd8 : fetch_dist[3:0];
    // An odd fetch address only needs one free byte (upper half of the word).
    assign room       = fetch_addr_q[0] ? (ipq_len <= 4'd7) : (ipq_len <= 4'd6);
    assign set_pc_ev  = set_pc & (ce_1 | ce_2);
    assign idx        = fetch_addr_q[2:0];
    assign idx_n      = idx + 3'd1;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        discard_d    = discard_q;
        bus_req_d    = bus_req_q;
        bus_fetch_d  = bus_fetch_q;
        bus_addr_d   = bus_addr_q;
        exec_grant_d = exec_grant_q;
        ipq_d        = ipq_q;

        if (set_pc_ev) begin
            fetch_addr_d = new_pc;
            if (state_q == PF_BUSY) discard_d = 1'b1;
        end

        if (ce_1) begin
            case (state_q)
                IDLE: begin
                    if (exec_req) begin
                        state_d      = EX_BUSY;
                        exec_grant_d = 1'b1;
                    end else if (!block_prefetch && !set_pc && room) begin
                        state_d     = PF_BUSY;
                        bus_req_d   = 1'b1;
                        bus_fetch_d = 1'b1;
                        bus_addr_d  = {fetch_addr_q[15:1], 1'b0};
                    end
                end
                PF_BUSY: begin
                    if (bus_ready) begin
                        state_d     = IDLE;
                        bus_req_d   = 1'b0;
                        bus_fetch_d = 1'b0;
                        discard_d   = 1'b0;
                        // A flush during (or on) the completing edge drops the data.
                        if (!discard_q && !set_pc_ev) begin
                            if (fetch_addr_q[0]) begin
                                ipq_d[idx]   = bus_din[15:8];
                                fetch_addr_d = fetch_addr_q + 16'd1;
                            end else begin
                                ipq_d[idx]   = bus_din[7:0];
                                ipq_d[idx_n] = bus_din[15:8];
                                fetch_addr_d = fetch_addr_q + 16'd2;
                            end
                        end
                    end
                end
                EX_BUSY: begin
                    if (exec_done) begin
                        state_d      = IDLE;
                        exec_grant_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_addr_q <= 16'h0000;
            discard_q    <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_fetch_q  <= 1'b0;
            bus_addr_q   <= 16'h0000;
            exec_grant_q <= 1'b0;
            ipq_q        <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            discard_q    <= discard_d;
            bus_req_q    <= bus_req_d;
            bus_fetch_q  <= bus_fetch_d;
            bus_addr_q   <= bus_addr_d;
            exec_grant_q <= exec_grant_d;
            ipq_q        <= ipq_d;
        end
    end

    assign ipq        = ipq_q;
    assign bus_req    = bus_req_q;
    assign bus_fetch  = bus_fetch_q;
    assign bus_addr   = bus_addr_q;
    assign exec_grant = exec_grant_q;
    assign dbg_state  = state_q;

endmodule
